// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave backed by a byte-writable 32-bit word array.
// Read and write paths are independent FSMs, so one read burst and one
// write burst may be in flight at the same time.
module axi_sram_slave #(
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  axi_ar_id,
  input  logic [1:0]  axi_ar_brust,
  input  logic [7:0]  axi_ar_len,
  input  logic [2:0]  axi_ar_size,
  input  logic [63:0] axi_ar_addr,
  input  logic        axi_ar_valid,
  output logic        axi_ar_ready,
  output logic [31:0] axi_r_data,
  output logic        axi_r_valid,
  output logic [3:0]  axi_r_id,
  output logic        axi_r_last,
  output logic [1:0]  axi_r_resp,
  input  logic        axi_r_ready,
  input  logic [3:0]  axi_aw_id,
  input  logic [1:0]  axi_aw_brust,
  input  logic [7:0]  axi_aw_len,
  input  logic [2:0]  axi_aw_size,
  input  logic [63:0] axi_aw_addr,
  input  logic        axi_aw_valid,
  output logic        axi_aw_ready,
  input  logic [31:0] axi_w_data,
  input  logic [3:0]  axi_w_strb,
  input  logic        axi_w_last,
  input  logic        axi_w_valid,
  output logic        axi_w_ready,
  output logic        axi_b_valid,
  output logic [1:0]  axi_b_resp,
  output logic [3:0]  axi_b_id,
  input  logic        axi_b_ready
);

  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) << 2;
  // Wait-state count loaded at AR handshake; unused when RD_LATENCY is 0.
  localparam logic [3:0]  LAT_M1    = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {RIdle, RWait, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} wr_state_e;

  logic [31:0] r_mem [MEM_DEPTH];

  // DECERR outranks SLVERR, so it is assigned last.
  function automatic logic [1:0] f_resp(input logic [63:0] addr, input logic [2:0] size,
                                        input logic [1:0] brust);
    logic [1:0] resp;
    resp = 2'b00;
    if (size > 3'd2 || brust[1]) resp = 2'b10;
    if (addr < BASE_ADDR || addr >= BASE_ADDR + MEM_BYTES) resp = 2'b11;
    return resp;
  endfunction

  function automatic logic [63:0] f_next(input logic [63:0] addr, input logic [2:0] size,
                                         input logic [1:0] brust);
    return (brust == 2'b01) ? addr + (64'd1 << size) : addr;
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [63:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // ---------------- Read path ----------------
  rd_state_e   r_rd_state, w_rd_state_nxt;
  logic [63:0] r_rd_addr;
  logic [7:0]  r_rd_cnt;
  logic [2:0]  r_rd_size;
  logic [1:0]  r_rd_brust;
  logic [3:0]  r_rd_wait;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs, w_r_hs, w_rd_load;
  logic [63:0] w_src_addr;
  logic [2:0]  w_src_size;
  logic [1:0]  w_src_brust;
  logic [1:0]  w_rd_resp;
  logic [31:0] w_rd_word;

  assign w_ar_hs    = axi_ar_valid & axi_ar_ready;
  assign w_r_hs     = axi_r_valid & axi_r_ready;
  assign axi_r_data = r_rdata;
  assign axi_r_resp = r_rresp;
  assign axi_r_id   = r_rid;

  // Read state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_state <= RIdle;
    else        r_rd_state <= w_rd_state_nxt;
  end

  // Read next-state logic.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RIdle: if (w_ar_hs) w_rd_state_nxt = (RD_LATENCY == 0) ? RData : RWait;
      RWait: if (r_rd_wait == 4'd0) w_rd_state_nxt = RData;
      RData: if (w_r_hs && r_rd_cnt == 8'd0) w_rd_state_nxt = RIdle;
      default: w_rd_state_nxt = RIdle;
    endcase
  end

  // Read handshake outputs.
  always_comb begin
    axi_ar_ready = (r_rd_state == RIdle);
    axi_r_valid  = (r_rd_state == RData);
    axi_r_last   = (r_rd_state == RData) && (r_rd_cnt == 8'd0);
  end

  // Address of the beat about to be presented; the array is sampled here so the
  // registered R payload stays stable under backpressure.
  always_comb begin
    w_src_addr  = r_rd_addr;
    w_src_size  = r_rd_size;
    w_src_brust = r_rd_brust;
    if (r_rd_state == RIdle) begin
      w_src_addr  = axi_ar_addr;
      w_src_size  = axi_ar_size;
      w_src_brust = axi_ar_brust;
    end else if (r_rd_state == RData) begin
      w_src_addr  = f_next(r_rd_addr, r_rd_size, r_rd_brust);
    end
    w_rd_resp = f_resp(w_src_addr, w_src_size, w_src_brust);
    w_rd_word = (w_rd_resp == 2'b00) ? r_mem[f_idx(w_src_addr)] : 32'd0;
    w_rd_load = ((r_rd_state == RIdle) && w_ar_hs && (RD_LATENCY == 0)) ||
                ((r_rd_state == RWait) && (r_rd_wait == 4'd0)) ||
                ((r_rd_state == RData) && w_r_hs && (r_rd_cnt != 8'd0));
  end

  // Read burst bookkeeping and R payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_rd_size  <= '0;
      r_rd_brust <= '0;
      r_rd_wait  <= '0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rd_addr  <= axi_ar_addr;
        r_rd_cnt   <= axi_ar_len;
        r_rd_size  <= axi_ar_size;
        r_rd_brust <= axi_ar_brust;
        r_rd_wait  <= LAT_M1;
        r_rid      <= axi_ar_id;
      end else if (r_rd_state == RWait && r_rd_wait != 4'd0) begin
        r_rd_wait <= r_rd_wait - 4'd1;
      end else if (w_r_hs && r_rd_cnt != 8'd0) begin
        r_rd_addr <= f_next(r_rd_addr, r_rd_size, r_rd_brust);
        r_rd_cnt  <= r_rd_cnt - 8'd1;
      end
      if (w_rd_load) begin
        r_rdata <= w_rd_word;
        r_rresp <= w_rd_resp;
      end
    end
  end

  // ---------------- Write path ----------------
  wr_state_e   r_wr_state, w_wr_state_nxt;
  logic [63:0] r_wr_addr;
  logic [7:0]  r_wr_cnt;
  logic [2:0]  r_wr_size;
  logic [1:0]  r_wr_brust;
  logic        r_wr_over;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic        w_aw_hs, w_w_hs, w_wr_en;
  logic [1:0]  w_wr_resp;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_aw_hs    = axi_aw_valid & axi_aw_ready;
  assign w_w_hs     = axi_w_valid & axi_w_ready;
  assign axi_b_id   = r_bid;
  assign axi_b_resp = r_bresp;
  assign w_wr_idx   = f_idx(r_wr_addr);
  // A last flag that disagrees with the beat count is a protocol error.
  assign w_wr_resp  = f_resp(r_wr_addr, r_wr_size, r_wr_brust) |
                      ((axi_w_last != (r_wr_cnt == 8'd0)) ? 2'b10 : 2'b00);
  assign w_wr_en    = w_w_hs && (w_wr_resp == 2'b00) && !r_wr_over;

  // Write state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_state <= WIdle;
    else        r_wr_state <= w_wr_state_nxt;
  end

  // Write next-state logic.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      WIdle: if (w_aw_hs) w_wr_state_nxt = WData;
      WData: if (w_w_hs && axi_w_last) w_wr_state_nxt = WResp;
      WResp: if (axi_b_ready) w_wr_state_nxt = WIdle;
      default: w_wr_state_nxt = WIdle;
    endcase
  end

  // Write handshake outputs.
  always_comb begin
    axi_aw_ready = (r_wr_state == WIdle);
    axi_w_ready  = (r_wr_state == WData);
    axi_b_valid  = (r_wr_state == WResp);
  end

  // Write burst bookkeeping and accumulated B response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr  <= '0;
      r_wr_cnt   <= '0;
      r_wr_size  <= '0;
      r_wr_brust <= '0;
      r_wr_over  <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= '0;
    end else if (w_aw_hs) begin
      r_wr_addr  <= axi_aw_addr;
      r_wr_cnt   <= axi_aw_len;
      r_wr_size  <= axi_aw_size;
      r_wr_brust <= axi_aw_brust;
      r_wr_over  <= 1'b0;
      r_bid      <= axi_aw_id;
      r_bresp    <= 2'b00;
    end else if (w_w_hs) begin
      r_wr_addr <= f_next(r_wr_addr, r_wr_size, r_wr_brust);
      r_wr_cnt  <= (r_wr_cnt == 8'd0) ? 8'd0 : r_wr_cnt - 8'd1;
      r_bresp   <= r_bresp | w_wr_resp;
      // Beats beyond len+1 are dropped until the master raises last.
      if (r_wr_cnt == 8'd0 && !axi_w_last) r_wr_over <= 1'b1;
    end
  end

  // Byte-lane writes into the (unreset) array.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_w_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= axi_w_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default parameters).
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  axi_ar_id;
  logic [1:0]  axi_ar_brust;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [63:0] axi_ar_addr;
  logic        axi_ar_valid, axi_ar_ready;
  logic [31:0] axi_r_data;
  logic        axi_r_valid, axi_r_last, axi_r_ready;
  logic [3:0]  axi_r_id;
  logic [1:0]  axi_r_resp;
  logic [3:0]  axi_aw_id;
  logic [1:0]  axi_aw_brust;
  logic [7:0]  axi_aw_len;
  logic [2:0]  axi_aw_size;
  logic [63:0] axi_aw_addr;
  logic        axi_aw_valid, axi_aw_ready;
  logic [31:0] axi_w_data;
  logic [3:0]  axi_w_strb;
  logic        axi_w_last, axi_w_valid, axi_w_ready;
  logic        axi_b_valid, axi_b_ready;
  logic [1:0]  axi_b_resp;
  logic [3:0]  axi_b_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Read collector results.
  logic [31:0] rd_dat [16];
  logic [1:0]  rd_rsp [16];
  logic        rd_lst [16];
  logic [3:0]  rd_idv [16];
  int          rd_n, rd_unstable;
  bit          rd_to;
  // Write driver data and results.
  logic [31:0] wr_dat [16];
  logic [1:0]  wr_bresp;
  logic [3:0]  wr_bid;
  int          wr_unstable, wr_bdelay;
  bit          wr_to;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .axi_ar_id(axi_ar_id), .axi_ar_brust(axi_ar_brust), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid), .axi_r_id(axi_r_id),
    .axi_r_last(axi_r_last), .axi_r_resp(axi_r_resp), .axi_r_ready(axi_r_ready),
    .axi_aw_id(axi_aw_id), .axi_aw_brust(axi_aw_brust), .axi_aw_len(axi_aw_len),
    .axi_aw_size(axi_aw_size), .axi_aw_addr(axi_aw_addr), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp), .axi_b_id(axi_b_id),
    .axi_b_ready(axi_b_ready)
  );

  // Issue one AR and collect len+1 R beats; optional random r_ready stalls.
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] brust, input bit stall);
    int g;
    logic held;
    logic [38:0] hv;
    rd_n = 0; rd_to = 0; rd_unstable = 0; held = 0; g = 0; hv = '0;
    @(negedge clk);
    axi_ar_id = id; axi_ar_addr = addr; axi_ar_len = len;
    axi_ar_size = size; axi_ar_brust = brust; axi_ar_valid = 1'b1;
    while (!axi_ar_ready && g < 50) begin @(negedge clk); g++; end
    if (!axi_ar_ready) rd_to = 1;
    @(negedge clk);
    axi_ar_valid = 1'b0;
    g = 0;
    while (rd_n <= int'(len) && g < 400) begin
      axi_r_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi_r_valid) begin
        if (held && hv !== {axi_r_data, axi_r_resp, axi_r_last, axi_r_id}) rd_unstable++;
        if (axi_r_ready) begin
          rd_dat[rd_n] = axi_r_data; rd_rsp[rd_n] = axi_r_resp;
          rd_lst[rd_n] = axi_r_last; rd_idv[rd_n] = axi_r_id;
          rd_n++; held = 0;
        end else begin
          held = 1; hv = {axi_r_data, axi_r_resp, axi_r_last, axi_r_id};
        end
      end
      @(negedge clk); g++;
    end
    axi_r_ready = 1'b0;
    if (rd_n <= int'(len)) rd_to = 1;
  endtask

  // Issue one AW, send nbeats of wr_dat (last on the final one), collect B.
  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] brust, input int nbeats,
                          input logic [3:0] strb, input bit stall);
    int g, i;
    logic held, done;
    logic [5:0] hv;
    wr_to = 0; wr_unstable = 0; wr_bdelay = -1; held = 0; done = 0; g = 0; i = 0; hv = '0;
    @(negedge clk);
    axi_aw_id = id; axi_aw_addr = addr; axi_aw_len = len;
    axi_aw_size = size; axi_aw_brust = brust; axi_aw_valid = 1'b1;
    while (!axi_aw_ready && g < 50) begin @(negedge clk); g++; end
    if (!axi_aw_ready) wr_to = 1;
    @(negedge clk);
    axi_aw_valid = 1'b0;
    g = 0;
    while (i < nbeats && g < 200) begin
      axi_w_valid = 1'b1; axi_w_data = wr_dat[i]; axi_w_strb = strb;
      axi_w_last = (i == nbeats - 1);
      if (axi_w_ready) i++;
      @(negedge clk); g++;
    end
    axi_w_valid = 1'b0; axi_w_last = 1'b0;
    if (i < nbeats) wr_to = 1;
    g = 0;
    while (!done && g < 200) begin
      axi_b_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi_b_valid) begin
        if (wr_bdelay < 0) wr_bdelay = g;
        if (held && hv !== {axi_b_resp, axi_b_id}) wr_unstable++;
        if (axi_b_ready) begin
          wr_bresp = axi_b_resp; wr_bid = axi_b_id; done = 1;
        end else begin
          held = 1; hv = {axi_b_resp, axi_b_id};
        end
      end
      @(negedge clk); g++;
    end
    axi_b_ready = 1'b0;
    if (!done) wr_to = 1;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (axi_ar_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ar_ready: got %b want 1", axi_ar_ready); end
    n_tests++; if (axi_aw_ready !== 1'b1) begin n_fail++; $display("FAIL rst_aw_ready: got %b want 1", axi_aw_ready); end
    n_tests++; if (axi_r_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r_valid: got %b want 0", axi_r_valid); end
    n_tests++; if (axi_r_last !== 1'b0) begin n_fail++; $display("FAIL rst_r_last: got %b want 0", axi_r_last); end
    n_tests++; if (axi_w_ready !== 1'b0) begin n_fail++; $display("FAIL rst_w_ready: got %b want 0", axi_w_ready); end
    n_tests++; if (axi_b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %b want 0", axi_b_valid); end
    n_tests++; if ({axi_r_data, axi_r_id, axi_r_resp, axi_b_id, axi_b_resp} !== 44'd0) begin
      n_fail++; $display("FAIL rst_payload: got %h/%h/%h/%h/%h want all 0",
                         axi_r_data, axi_r_id, axi_r_resp, axi_b_id, axi_b_resp);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (axi_ar_ready !== 1'b1 || axi_r_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle: got ar_ready=%b r_valid=%b want 1/0", axi_ar_ready, axi_r_valid);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wr_dat[i] = 32'h1111_1111 * (i + 1);
    do_write(4'h5, 64'h8000_0010, 8'd3, 3'd2, 2'b01, 4, 4'hF, 0);
    n_tests++; if (wr_to !== 1'b0) begin n_fail++; $display("FAIL incr_wr_timeout: got %b want 0", wr_to); end
    n_tests++; if (wr_bresp !== 2'b00) begin n_fail++; $display("FAIL incr_bresp: got %b want 00", wr_bresp); end
    n_tests++; if (wr_bid !== 4'h5) begin n_fail++; $display("FAIL incr_bid: got %h want 5", wr_bid); end
    n_tests++; if (wr_bdelay !== 0) begin n_fail++; $display("FAIL incr_b_latency: got %0d want 0", wr_bdelay); end
    do_read(4'h9, 64'h8000_0010, 8'd3, 3'd2, 2'b01, 0);
    n_tests++; if (rd_to !== 1'b0) begin n_fail++; $display("FAIL incr_rd_timeout: got %b want 0", rd_to); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_dat[i] !== 32'h1111_1111 * (i + 1) || rd_rsp[i] !== 2'b00 ||
          rd_lst[i] !== (i == 3) || rd_idv[i] !== 4'h9) begin
        n_fail++;
        $display("FAIL incr_rbeat[%0d]: got d=%h r=%b l=%b id=%h want d=%h r=00 l=%b id=9", i,
                 rd_dat[i], rd_rsp[i], rd_lst[i], rd_idv[i], 32'h1111_1111 * (i + 1), i == 3);
      end
    end
  endtask

  task automatic test_strobe_fixed();
    wr_dat[0] = 32'h0;
    do_write(4'h1, 64'h8000_0000, 8'd0, 3'd2, 2'b01, 1, 4'hF, 0);
    wr_dat[0] = 32'hAABB_CCDD;
    do_write(4'h1, 64'h8000_0000, 8'd0, 3'd2, 2'b01, 1, 4'b0101, 0);
    n_tests++; if (wr_bresp !== 2'b00) begin n_fail++; $display("FAIL strb_bresp: got %b want 00", wr_bresp); end
    do_read(4'h2, 64'h8000_0000, 8'd0, 3'd2, 2'b01, 0);
    n_tests++; if (rd_dat[0] !== 32'h00BB_00DD || rd_lst[0] !== 1'b1) begin
      n_fail++; $display("FAIL strb_data: got %h last=%b want 00bb00dd last=1", rd_dat[0], rd_lst[0]);
    end
    // FIXED write: both beats land on 0x8000_0020, the second wins.
    wr_dat[0] = 32'hA5A5_0001; wr_dat[1] = 32'h5A5A_0002;
    do_write(4'h3, 64'h8000_0020, 8'd1, 3'd2, 2'b00, 2, 4'hF, 0);
    do_read(4'h3, 64'h8000_001C, 8'd1, 3'd2, 2'b01, 0);
    n_tests++; if (rd_dat[0] !== 32'h4444_4444 || rd_dat[1] !== 32'h5A5A_0002) begin
      n_fail++; $display("FAIL fixed_write: got %h %h want 44444444 5a5a0002", rd_dat[0], rd_dat[1]);
    end
    do_read(4'h3, 64'h8000_0010, 8'd1, 3'd2, 2'b00, 0);
    n_tests++; if (rd_dat[0] !== 32'h1111_1111 || rd_dat[1] !== 32'h1111_1111) begin
      n_fail++; $display("FAIL fixed_read: got %h %h want 11111111 11111111", rd_dat[0], rd_dat[1]);
    end
  endtask

  task automatic test_decerr();
    do_read(4'h4, 64'h7FFF_FFF8, 8'd1, 3'd2, 2'b01, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (rd_rsp[i] !== 2'b11 || rd_dat[i] !== 32'd0 || rd_lst[i] !== (i == 1)) begin
        n_fail++; $display("FAIL low_decerr[%0d]: got r=%b d=%h l=%b want r=11 d=0 l=%b",
                           i, rd_rsp[i], rd_dat[i], rd_lst[i], i == 1);
      end
    end
    wr_dat[0] = 32'hCAFE_F00D;
    do_write(4'h4, 64'h8000_3FFC, 8'd0, 3'd2, 2'b01, 1, 4'hF, 0);
    do_read(4'h4, 64'h8000_3FFC, 8'd1, 3'd2, 2'b01, 0);
    n_tests++; if (rd_rsp[0] !== 2'b00 || rd_dat[0] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL top_word: got r=%b d=%h want r=00 d=cafef00d", rd_rsp[0], rd_dat[0]);
    end
    n_tests++; if (rd_rsp[1] !== 2'b11 || rd_dat[1] !== 32'd0) begin
      n_fail++; $display("FAIL top_decerr: got r=%b d=%h want r=11 d=0", rd_rsp[1], rd_dat[1]);
    end
    wr_dat[0] = 32'hDEAD_BEEF;
    do_write(4'h6, 64'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 1, 4'hF, 0);
    n_tests++; if (wr_bresp !== 2'b11) begin n_fail++; $display("FAIL wr_decerr: got %b want 11", wr_bresp); end
    do_read(4'h4, 64'h8000_3FFC, 8'd0, 3'd2, 2'b01, 0);
    n_tests++; if (rd_dat[0] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL decerr_nowrite: got %h want cafef00d", rd_dat[0]);
    end
  endtask

  task automatic test_slverr();
    for (int i = 0; i < 4; i++) wr_dat[i] = 32'h1234_0000 + i;
    do_write(4'h6, 64'h8000_0040, 8'd3, 3'd2, 2'b01, 2, 4'hF, 0);
    n_tests++; if (wr_to !== 1'b0 || wr_bdelay !== 0) begin
      n_fail++; $display("FAIL early_last_end: got to=%b bdelay=%0d want 0/0", wr_to, wr_bdelay);
    end
    n_tests++; if (wr_bresp !== 2'b10 || wr_bid !== 4'h6) begin
      n_fail++; $display("FAIL early_last_bresp: got %b id=%h want 10 id=6", wr_bresp, wr_bid);
    end
    do_read(4'h7, 64'h8000_0010, 8'd1, 3'd3, 2'b01, 0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (rd_rsp[i] !== 2'b10 || rd_dat[i] !== 32'd0) begin
        n_fail++; $display("FAIL size3_slverr[%0d]: got r=%b d=%h want r=10 d=0", i, rd_rsp[i], rd_dat[i]);
      end
    end
    do_read(4'h7, 64'h8000_0010, 8'd0, 3'd2, 2'b10, 0);
    n_tests++; if (rd_rsp[0] !== 2'b10 || rd_to !== 1'b0) begin
      n_fail++; $display("FAIL wrap_slverr: got r=%b to=%b want 10/0", rd_rsp[0], rd_to);
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 8; i++) wr_dat[i] = 32'hC0DE_0000 + i;
    fork
      do_write(4'hA, 64'h8000_0100, 8'd7, 3'd2, 2'b01, 8, 4'hF, 1);
      do_read(4'hB, 64'h8000_0010, 8'd3, 3'd2, 2'b01, 1);
    join
    n_tests++; if (rd_to !== 1'b0 || rd_unstable !== 0) begin
      n_fail++; $display("FAIL conc_rd: got to=%b unstable=%0d want 0/0", rd_to, rd_unstable);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_dat[i] !== 32'h1111_1111 * (i + 1) || rd_lst[i] !== (i == 3)) begin
        n_fail++; $display("FAIL conc_rdata[%0d]: got %h l=%b want %h l=%b", i, rd_dat[i],
                           rd_lst[i], 32'h1111_1111 * (i + 1), i == 3);
      end
    end
    n_tests++; if (wr_to !== 1'b0 || wr_unstable !== 0 || wr_bresp !== 2'b00 || wr_bid !== 4'hA) begin
      n_fail++; $display("FAIL conc_wr: got to=%b unstable=%0d resp=%b id=%h want 0/0/00/a",
                         wr_to, wr_unstable, wr_bresp, wr_bid);
    end
    do_read(4'hC, 64'h8000_0100, 8'd7, 3'd2, 2'b01, 1);
    n_tests++; if (rd_unstable !== 0 || rd_to !== 1'b0) begin
      n_fail++; $display("FAIL conc_readback_hold: got unstable=%0d to=%b want 0/0", rd_unstable, rd_to);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rd_dat[i] !== 32'hC0DE_0000 + i) begin
        n_fail++; $display("FAIL conc_readback[%0d]: got %h want %h", i, rd_dat[i], 32'hC0DE_0000 + i);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    axi_ar_id = 4'hD; axi_ar_addr = 64'h8000_0010; axi_ar_len = 8'd3;
    axi_ar_size = 3'd2; axi_ar_brust = 2'b01; axi_ar_valid = 1'b1; axi_r_ready = 1'b0;
    @(negedge clk);
    axi_ar_valid = 1'b0;
    n_tests++; if (axi_r_valid !== 1'b0) begin n_fail++; $display("FAIL rlat_early: got %b want 0", axi_r_valid); end
    @(negedge clk);
    n_tests++; if (axi_r_valid !== 1'b1 || axi_r_data !== 32'h1111_1111 || axi_r_id !== 4'hD || axi_r_last !== 1'b0) begin
      n_fail++; $display("FAIL rlat_first: got v=%b d=%h id=%h l=%b want 1/11111111/d/0",
                         axi_r_valid, axi_r_data, axi_r_id, axi_r_last);
    end
    axi_r_ready = 1'b1;
    @(negedge clk);
    axi_r_ready = 1'b0;
    n_tests++; if (axi_r_data !== 32'h2222_2222) begin
      n_fail++; $display("FAIL rbeat2: got %h want 22222222", axi_r_data);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (axi_r_valid !== 1'b0 || axi_ar_ready !== 1'b1 || axi_r_data !== 32'd0) begin
      n_fail++; $display("FAIL mid_rst: got v=%b ar_ready=%b d=%h want 0/1/0",
                         axi_r_valid, axi_ar_ready, axi_r_data);
    end
    @(negedge clk); rst_n = 1'b1;
    do_read(4'hE, 64'h8000_0014, 8'd0, 3'd2, 2'b01, 0);
    n_tests++; if (rd_to !== 1'b0 || rd_dat[0] !== 32'h2222_2222 || rd_idv[0] !== 4'hE) begin
      n_fail++; $display("FAIL post_rst_read: got to=%b d=%h id=%h want 0/22222222/e",
                         rd_to, rd_dat[0], rd_idv[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    axi_ar_id = '0; axi_ar_brust = '0; axi_ar_len = '0; axi_ar_size = '0; axi_ar_addr = '0;
    axi_ar_valid = 1'b0; axi_r_ready = 1'b0;
    axi_aw_id = '0; axi_aw_brust = '0; axi_aw_len = '0; axi_aw_size = '0; axi_aw_addr = '0;
    axi_aw_valid = 1'b0; axi_w_data = '0; axi_w_strb = '0; axi_w_last = 1'b0;
    axi_w_valid = 1'b0; axi_b_ready = 1'b0;
    test_reset();
    test_incr();
    test_strobe_fixed();
    test_decerr();
    test_slverr();
    test_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
